// File: rtl/key_debouncer_if.sv
// Key bus between the raw board pins, the debouncer and the buttons device.
// The slave side is the debouncer; the master side drives the raw pins and consumes the clean keys.
interface key_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] raw_key;
    logic [WIDTH-1:0] user_key;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    modport master (
        output raw_key,
        input  user_key,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  raw_key,
        output user_key,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debounce_cell.sv
// One key's debounce filter: counts sample ticks spent disagreeing with the
// debounced state and flips after STABLE_TICKS of them, with edge strobes.
module key_debounce_cell #(
    parameter int STABLE_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync_bit,
    output logic key_q,
    output logic press_q,
    output logic release_q
);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt;

    // Any agreement clears progress, so short bounces never accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            key_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (sync_bit == key_q) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    key_q     <= sync_bit;
                    press_q   <= ~sync_bit;
                    release_q <= sync_bit;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/key_debouncer.sv
// Debounces WIDTH active-low key pins: two-flop synchroniser, shared sample
// prescaler and one filter cell per key; all outputs are registered.
module key_debouncer #(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 20
) (
    input  logic           clk,
    input  logic           rst,
    key_debouncer_if.slave kbus
);
    localparam logic [WIDTH-1:0] KEY_IDLE = {WIDTH{1'b1}};
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    psc;
    logic             tick;
    logic [WIDTH-1:0] user_key_q;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] release_q;

    // Synchroniser resets to the idle level so reset exit looks like "no key pressed".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= KEY_IDLE;
            sync2 <= KEY_IDLE;
        end else begin
            sync1 <= kbus.raw_key;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler shared by all keys; key activity never restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc <= '0;
        end else if (psc == PSC_LAST) begin
            psc <= '0;
        end else begin
            psc <= psc + PW'(1);
        end
    end

    assign tick = (psc == PSC_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .sync_bit (sync2[i]),
            .key_q    (user_key_q[i]),
            .press_q  (press_q[i]),
            .release_q(release_q[i])
        );
    end

    assign kbus.user_key      = user_key_q;
    assign kbus.press_pulse   = press_q;
    assign kbus.release_pulse = release_q;
endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: a slow-tick instance (TICK_DIV=4, STABLE_TICKS=3) and a
// fastest instance (1/1), both compared every cycle against a behavioural model.
module tb_key_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_debouncer_if #(.WIDTH(8)) bus_a ();
    key_debouncer_if #(.WIDTH(8)) bus_b ();

    key_debouncer #(.WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .kbus(bus_a)
    );

    key_debouncer #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .kbus(bus_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Behavioural model: the synchronised input is the raw pins seen two edges
    // earlier; a sample tick falls on every TICK_DIV-th edge after reset; a key
    // flips once it has disagreed for STABLE_TICKS ticks in a row.
    int         m_div [2] = '{4, 1};
    int         m_need[2] = '{3, 1};
    int         m_edges[2];
    logic [7:0] m_seen1[2];
    logic [7:0] m_seen2[2];
    logic [7:0] m_key  [2];
    logic [7:0] m_prs  [2];
    logic [7:0] m_rel  [2];
    int         m_ticks[2][8];

    function automatic logic [7:0] raw_of(input int d);
        return (d == 0) ? bus_a.raw_key : bus_b.raw_key;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_edges[d] = 0;
            m_seen1[d] = 8'hFF;
            m_seen2[d] = 8'hFF;
            m_key[d]   = 8'hFF;
            m_prs[d]   = 8'h00;
            m_rel[d]   = 8'h00;
            for (int i = 0; i < 8; i++) m_ticks[d][i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit         is_tick;
            logic [7:0] seen;
            is_tick  = (m_edges[d] % m_div[d]) == (m_div[d] - 1);
            seen     = m_seen2[d];
            m_prs[d] = 8'h00;
            m_rel[d] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (seen[i] == m_key[d][i]) begin
                    m_ticks[d][i] = 0;
                end else if (is_tick) begin
                    m_ticks[d][i] = m_ticks[d][i] + 1;
                    if (m_ticks[d][i] == m_need[d]) begin
                        m_ticks[d][i] = 0;
                        m_key[d][i]   = seen[i];
                        if (seen[i]) m_rel[d][i] = 1'b1;
                        else         m_prs[d][i] = 1'b1;
                    end
                end
            end
            m_seen2[d] = m_seen1[d];
            m_seen1[d] = raw_of(d);
            m_edges[d] = m_edges[d] + 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_edge();
        end
    end

    always @(negedge clk) begin
        chk("a_user_key", bus_a.user_key, m_key[0]);
        chk("a_press", bus_a.press_pulse, m_prs[0]);
        chk("a_release", bus_a.release_pulse, m_rel[0]);
        chk("b_user_key", bus_b.user_key, m_key[1]);
        chk("b_press", bus_b.press_pulse, m_prs[1]);
        chk("b_release", bus_b.release_pulse, m_rel[1]);
    end

    task automatic wait_user(input int d, input logic [7:0] val, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((d == 0) ? bus_a.user_key : bus_b.user_key) !== val && n < lim);
    endtask

    initial begin
        int         n;
        logic [7:0] pulses_seen;
        logic [7:0] prev_user;
        bit         shape_ok;
        logic [7:0] msk;

        bus_a.raw_key = 8'h00;
        bus_b.raw_key = 8'hFF;

        // Reset with all keys held down.
        repeat (3) @(negedge clk);
        chk("rst_user_key", bus_a.user_key, 8'hFF);
        chk("rst_press", bus_a.press_pulse, 8'h00);
        chk("rst_release", bus_a.release_pulse, 8'h00);
        #2 rst = 1'b1;
        wait_user(0, 8'h00, 40, n);
        chk_int("rst_exit_latency", n, 12, 12);
        chk("rst_exit_press", bus_a.press_pulse, 8'hFF);
        @(negedge clk);
        chk("rst_exit_press_end", bus_a.press_pulse, 8'h00);

        // Clean press of key 0.
        bus_a.raw_key = 8'hFF;
        wait_user(0, 8'hFF, 40, n);
        repeat (3) @(negedge clk);
        bus_a.raw_key = 8'hFE;
        wait_user(0, 8'hFE, 40, n);
        chk_int("press_latency", n, 11, 14);
        chk("press_strobe", bus_a.press_pulse, 8'h01);
        chk("press_no_release", bus_a.release_pulse, 8'h00);
        @(negedge clk);
        chk("press_strobe_end", bus_a.press_pulse, 8'h00);

        // Bounce on key 0 shorter than one tick window.
        bus_a.raw_key = 8'hFF;
        wait_user(0, 8'hFF, 40, n);
        repeat (3) @(negedge clk);
        pulses_seen = 8'h00;
        for (int c = 0; c < 40; c++) begin
            bus_a.raw_key = (((c / 3) % 2) == 0) ? 8'hFE : 8'hFF;
            @(negedge clk);
            pulses_seen |= bus_a.press_pulse | bus_a.release_pulse | ~bus_a.user_key;
        end
        repeat (10) begin
            @(negedge clk);
            pulses_seen |= bus_a.press_pulse | bus_a.release_pulse | ~bus_a.user_key;
        end
        chk("bounce_activity", pulses_seen, 8'h00);
        chk("bounce_user_key", bus_a.user_key, 8'hFF);

        // Four keys released together.
        bus_a.raw_key = 8'hF0;
        wait_user(0, 8'hF0, 40, n);
        repeat (2) @(negedge clk);
        bus_a.raw_key = 8'hFF;
        shape_ok = 1'b1;
        n = 0;
        prev_user = bus_a.user_key;
        do begin
            @(negedge clk);
            n++;
            if (bus_a.user_key !== 8'hF0 && bus_a.user_key !== 8'hFF) shape_ok = 1'b0;
            if (bus_a.user_key === 8'hFF) prev_user = 8'hFF;
        end while (prev_user !== 8'hFF && n < 40);
        chk_int("multi_release_latency", n, 11, 14);
        chk_int("multi_release_one_step", int'(shape_ok), 1, 1);
        chk("multi_release_strobe", bus_a.release_pulse, 8'h0F);

        // Reset in the middle of a debounce on key 3.
        repeat (2) @(negedge clk);
        bus_a.raw_key = 8'hF7;
        repeat (10) @(negedge clk);
        chk("mid_no_flip_yet", bus_a.user_key, 8'hFF);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        wait_user(0, 8'hF7, 40, n);
        chk_int("mid_rst_full_latency", n, 12, 12);
        chk("mid_rst_press", bus_a.press_pulse, 8'h08);

        // Reset acts without waiting for a clock edge.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_user_key", bus_a.user_key, 8'hFF);
        @(negedge clk);
        #2 rst = 1'b1;
        bus_a.raw_key = 8'hFF;
        repeat (20) @(negedge clk);

        // Fastest parameters: fixed three-edge latency, glitch gives both strobes.
        bus_b.raw_key = 8'hFE;
        wait_user(1, 8'hFE, 10, n);
        chk_int("fast_latency", n, 3, 3);
        chk("fast_press", bus_b.press_pulse, 8'h01);
        repeat (2) @(negedge clk);
        bus_b.raw_key = 8'hFC;
        @(negedge clk);
        bus_b.raw_key = 8'hFE;
        @(negedge clk);
        chk("glitch_quiet", bus_b.press_pulse, 8'h00);
        @(negedge clk);
        chk("glitch_press", bus_b.press_pulse, 8'h02);
        chk("glitch_user_low", bus_b.user_key, 8'hFC);
        @(negedge clk);
        chk("glitch_release", bus_b.release_pulse, 8'h02);
        chk("glitch_user_back", bus_b.user_key, 8'hFE);

        // Random bouncy and calm phases with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            int p;
            @(negedge clk);
            p = (((c / 150) % 2) == 0) ? 4 : 60;
            msk = 8'h00;
            for (int i = 0; i < 8; i++) if ($urandom_range(0, p - 1) == 0) msk[i] = 1'b1;
            bus_a.raw_key = bus_a.raw_key ^ msk;
            msk = 8'h00;
            for (int i = 0; i < 8; i++) if ($urandom_range(0, p - 1) == 0) msk[i] = 1'b1;
            bus_b.raw_key = bus_b.raw_key ^ msk;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
